// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: loads an image and a square kernel from read memories, then streams out every valid convolution window result
module conv2d_stream_engine #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    localparam int NPIX  = IMG_W * IMG_H,
    localparam int KK    = K * K,
    localparam int OH    = (IMG_H - K) / STRIDE + 1,
    localparam int OW    = (IMG_W - K) / STRIDE + 1,
    localparam int IAW   = NPIX > 1 ? $clog2(NPIX) : 1,
    localparam int KAW   = KK > 1 ? $clog2(KK) : 1,
    localparam int RW    = OH > 1 ? $clog2(OH) : 1,
    localparam int CW    = OW > 1 ? $clog2(OW) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IAW-1:0]   img_addr,
    input  logic [DW-1:0]    img_rdata,
    output logic [KAW-1:0]   ker_addr,
    input  logic [DW-1:0]    ker_rdata,
    output logic [ACC_W-1:0] out_data,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam int CNTW = $clog2(NPIX + 1);
    localparam int KW   = K > 1 ? $clog2(K) : 1;

    if (ACC_W < 2 * DW + $clog2(KK)) begin : g_acc_width_check
        $error("ACC_W too narrow for the worst-case window sum");
    end

    typedef enum logic [2:0] {IDLE, LOAD, MAC, PRESENT, FINISH} state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [KW-1:0]    ki, kj;
    logic [ACC_W-1:0] acc;
    logic [DW-1:0]    pix [NPIX];
    logic [DW-1:0]    ker [KK];

    logic             last_i, last_j;
    logic [IAW-1:0]   pa;
    logic [KAW-1:0]   ka;
    logic [ACC_W-1:0] prod;

    // current window tap: pixel under kernel position (ki, kj) times its weight
    always_comb begin
        last_i = ki == KW'(K - 1);
        last_j = kj == KW'(K - 1);
        pa     = IAW'((int'(out_row) * STRIDE + int'(ki)) * IMG_W + int'(out_col) * STRIDE + int'(kj));
        ka     = KAW'(int'(ki) * K + int'(kj));
        prod   = ACC_W'(pix[pa]) * ACC_W'(ker[ka]);
    end

    // buffer fill: data arrives one cycle after its address, so entry cnt-1 is written at count cnt
    always_ff @(posedge clk) begin
        if (state == LOAD && cnt != '0) begin
            pix[IAW'(cnt - CNTW'(1))] <= img_rdata;
            if (cnt <= CNTW'(KK))
                ker[KAW'(cnt - CNTW'(1))] <= ker_rdata;
        end
    end

    // control FSM: load, per-window MAC, result handshake, done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ki        <= '0;
            kj        <= '0;
            acc       <= '0;
            img_addr  <= '0;
            ker_addr  <= '0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    cnt      <= '0;
                    img_addr <= '0;
                    ker_addr <= '0;
                    out_row  <= '0;
                    out_col  <= '0;
                    busy     <= 1'b1;
                end
                LOAD: begin
                    cnt      <= cnt + CNTW'(1);
                    img_addr <= cnt < CNTW'(NPIX - 1) ? img_addr + IAW'(1) : img_addr;
                    ker_addr <= cnt < CNTW'(KK - 1) ? ker_addr + KAW'(1) : ker_addr;
                    if (cnt == CNTW'(NPIX)) begin
                        state <= MAC;
                        ki    <= '0;
                        kj    <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    kj  <= last_j ? '0 : kj + KW'(1);
                    ki  <= last_j ? (last_i ? '0 : ki + KW'(1)) : ki;
                    acc <= last_i && last_j ? '0 : acc + prod;
                    if (last_i && last_j) begin
                        state     <= PRESENT;
                        out_data  <= acc + prod;
                        out_valid <= 1'b1;
                    end
                end
                PRESENT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (out_col == CW'(OW - 1)) begin
                        out_col <= '0;
                        out_row <= out_row == RW'(OH - 1) ? '0 : out_row + RW'(1);
                        state   <= out_row == RW'(OH - 1) ? FINISH : MAC;
                        done    <= out_row == RW'(OH - 1);
                        busy    <= out_row != RW'(OH - 1);
                    end else begin
                        out_col <= out_col + CW'(1);
                        state   <= MAC;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: three engine configurations checked against a plain-arithmetic convolution model
module tb_conv2d_stream_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start_v = '0;
    logic       out_ready = 1'b1;
    int         sel = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] img_mem [784];
    logic [7:0] ker_mem [9];

    logic [3:0]  a_ia, b_ia;
    logic [9:0]  c_ia;
    logic [1:0]  a_ka, b_ka;
    logic [3:0]  c_ka;
    logic [7:0]  a_ir, a_kr, b_ir, b_kr, c_ir, c_kr;
    logic [23:0] a_d, b_d, c_d;
    logic [1:0]  a_r, a_c;
    logic [0:0]  b_r, b_c;
    logic [4:0]  c_r, c_c;
    logic        a_v, a_b, a_dn, b_v, b_b, b_dn, c_v, c_b, c_dn;

    logic [23:0] o_d;
    logic [7:0]  o_r, o_c;
    logic [9:0]  o_ia;
    logic [3:0]  o_ka;
    logic        o_v, o_b, o_dn;

    always #5 clk = ~clk;

    conv2d_stream_engine #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(1)) u_a (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .img_addr(a_ia), .img_rdata(a_ir), .ker_addr(a_ka), .ker_rdata(a_kr),
        .out_data(a_d), .out_row(a_r), .out_col(a_c), .out_valid(a_v), .out_ready(out_ready),
        .busy(a_b), .done(a_dn));

    conv2d_stream_engine #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2)) u_b (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .img_addr(b_ia), .img_rdata(b_ir), .ker_addr(b_ka), .ker_rdata(b_kr),
        .out_data(b_d), .out_row(b_r), .out_col(b_c), .out_valid(b_v), .out_ready(out_ready),
        .busy(b_b), .done(b_dn));

    conv2d_stream_engine u_c (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .img_addr(c_ia), .img_rdata(c_ir), .ker_addr(c_ka), .ker_rdata(c_kr),
        .out_data(c_d), .out_row(c_r), .out_col(c_c), .out_valid(c_v), .out_ready(out_ready),
        .busy(c_b), .done(c_dn));

    always @(posedge clk) begin
        a_ir <= img_mem[int'(a_ia)];
        a_kr <= ker_mem[int'(a_ka)];
        b_ir <= img_mem[int'(b_ia)];
        b_kr <= ker_mem[int'(b_ka)];
        c_ir <= img_mem[int'(c_ia)];
        c_kr <= ker_mem[int'(c_ka)];
    end

    always_comb begin
        o_d  = sel == 0 ? a_d : sel == 1 ? b_d : c_d;
        o_r  = sel == 0 ? 8'(a_r) : sel == 1 ? 8'(b_r) : 8'(c_r);
        o_c  = sel == 0 ? 8'(a_c) : sel == 1 ? 8'(b_c) : 8'(c_c);
        o_ia = sel == 0 ? 10'(a_ia) : sel == 1 ? 10'(b_ia) : c_ia;
        o_ka = sel == 0 ? 4'(a_ka) : sel == 1 ? 4'(b_ka) : c_ka;
        o_v  = sel == 0 ? a_v : sel == 1 ? b_v : c_v;
        o_b  = sel == 0 ? a_b : sel == 1 ? b_b : c_b;
        o_dn = sel == 0 ? a_dn : sel == 1 ? b_dn : c_dn;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_pass(input int d, input bit rnd, input int stall_at, input int reset_at,
                            input bit noise, input bit hold);
        int w, k, s, oh, ow, n, kk, p, cyc, got, stall_left, since, acc;
        bit fin, first;
        logic [23:0] exq[$];
        logic [63:0] snap;
        w  = d == 2 ? 28 : 4;
        k  = d == 2 ? 3 : 2;
        s  = d == 1 ? 2 : 1;
        oh = (w - k) / s + 1;
        ow = (w - k) / s + 1;
        n  = w * w + 1;
        kk = k * k;
        p  = oh * ow;
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                acc = 0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++)
                        acc += int'(img_mem[(r * s + i) * w + c * s + j]) * int'(ker_mem[i * k + j]);
                exq.push_back(24'(acc));
            end
        sel = d;
        stall_left = 5;
        since = 100;
        got = 0;
        fin = 0;
        first = 0;
        snap = '0;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        cyc = 1;
        while (!fin && cyc < 20000) begin
            if (reset_at >= 0 && got == reset_at && since == 2) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_valid", 64'(o_v), 0);
                chk("rst_busy", 64'(o_b), 0);
                chk("rst_done", 64'(o_dn), 0);
                chk("rst_img_addr", 64'(o_ia), 0);
                chk("rst_ker_addr", 64'(o_ka), 0);
                return;
            end
            if (o_v && !first) begin
                first = 1;
                if (!rnd && stall_at < 0) chk("first_valid_cycle", 64'(cyc), 64'(n + kk + 1));
            end
            if (o_dn) begin
                chk("done_busy", 64'(o_b), 0);
                chk("done_count", 64'(got), 64'(p));
                if (!rnd && stall_at < 0) chk("done_cycle", 64'(cyc), 64'(n + p * (kk + 1) + 1));
                fin = 1;
            end else begin
                chk("busy_high", 64'(o_b), 1);
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_at >= 0 && got == stall_at && o_v && stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == 5) snap = 64'({o_d, o_r, o_c, o_ia, o_ka});
                else chk("stall_hold", 64'({o_d, o_r, o_c, o_ia, o_ka}), snap);
                stall_left--;
            end
            start_v[d] = (noise && (cyc == 3 || (o_v && got == 1))) || (hold && o_dn);
            if (o_v && out_ready) begin
                if (got < p) begin
                    chk("result_data", 64'(o_d), 64'(exq[got]));
                    chk("result_row", 64'(o_r), 64'(got / ow));
                    chk("result_col", 64'(o_c), 64'(got % ow));
                end else begin
                    chk("extra_result", 64'(o_v), 0);
                end
                got++;
                since = 0;
            end
            @(posedge clk); #1;
            cyc++;
            since++;
        end
        out_ready = 1'b1;
        chk("pass_finished", 64'(fin), 1);
        chk("done_single", 64'(o_dn), 0);
        chk("idle_busy", 64'(o_b), 0);
        if (hold) begin
            @(posedge clk); #1;
            start_v[d] = 1'b0;
            chk("hold_restart_in_idle", 64'(o_b), 1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        start_v[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 784; i++) img_mem[i] = '0;
        for (int i = 0; i < 9; i++) ker_mem[i] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk("reset_valid", 64'(o_v), 0);
            chk("reset_busy", 64'(o_b), 0);
            chk("reset_done", 64'(o_dn), 0);
            chk("reset_outs", 64'({o_d, o_r, o_c, o_ia, o_ka}), 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) img_mem[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) ker_mem[i] = 8'd1;
        run_pass(0, 0, -1, -1, 0, 0);
        run_pass(1, 0, -1, -1, 0, 0);
        run_pass(0, 0, 1, -1, 0, 0);
        run_pass(0, 0, -1, 2, 0, 0);
        run_pass(0, 0, -1, -1, 0, 0);
        run_pass(0, 0, -1, -1, 1, 1);
        for (int i = 0; i < 784; i++) img_mem[i] = 8'd255;
        for (int i = 0; i < 9; i++) ker_mem[i] = 8'd255;
        run_pass(2, 0, -1, -1, 0, 0);
        for (int i = 0; i < 784; i++) img_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) ker_mem[i] = 8'($urandom_range(0, 255));
        run_pass(0, 1, -1, -1, 0, 0);
        run_pass(1, 1, -1, -1, 0, 0);
        run_pass(2, 1, -1, -1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
